demux4_tdm_rx: RTL and testbench

DEMUX4_TDM_RX -- requirements
Module: demux4_tdm_rx

---
 rtl/demux4_tdm_rx.sv | 131 +++++++++++++
 tb/tb_demux4_tdm_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux4_tdm_rx.sv
// rtl/demux4_tdm_rx.sv - four-slot TDM receive demultiplexer with frame lock tracking
//
// Splits a time-division-multiplexed word stream into four registered lanes.
// A frame is four words; the slot-0 word is marked by frame_sync. The FSM hunts
// for the first sync, then tracks slots and flags sync anomalies.
//
// Optional feature macro: DEMUX4_TDM_PARITY_EN (adds din_par / par_err).
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   din         in   [WIDTH-1:0] TDM data word
//   din_valid   in   din valid this cycle
//   frame_sync  in   din is the slot-0 word (qualified by din_valid)
//   out0..out3  out  [WIDTH-1:0] registered lanes
//   out_valid   out  [3:0] one-cycle per-lane update strobe
//   frame_done  out  pulse when the slot-3 word is written
//   sync_err    out  pulse on unexpected or missing frame_sync
//   locked      out  high while in LOCKED
//   din_par     in   even parity over din (parity build only)
//   par_err     out  pulse with the strobe of a word failing parity (parity build only)

module demux4_tdm_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked
`ifdef DEMUX4_TDM_PARITY_EN
  ,
  input  logic             din_par,
  output logic             par_err
`endif
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state;
  logic [1:0] slot;

  // Per-cycle decision: accept the word into a lane, flag an error, or drop lock.
  logic       acc;
  logic [1:0] lane;
  logic       err;
  logic       lose;

  always_comb begin
    acc  = 1'b0;
    lane = slot;
    err  = 1'b0;
    lose = 1'b0;
    if (din_valid) begin
      if (state == HUNT) begin
        if (frame_sync) begin
          acc  = 1'b1;
          lane = 2'd0;
        end
      end else if (frame_sync && slot != 2'd0) begin
        // Early sync: resynchronise on this word as the new slot 0.
        err  = 1'b1;
        acc  = 1'b1;
        lane = 2'd0;
      end else if (!frame_sync && slot == 2'd0) begin
        // Slot 0 arrived without its sync marker: lock is lost, word dropped.
        err  = 1'b1;
        lose = 1'b1;
      end else begin
        acc  = 1'b1;
        lane = slot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      slot       <= 2'd0;
      out0       <= '0;
      out1       <= '0;
      out2       <= '0;
      out3       <= '0;
      out_valid  <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      locked     <= 1'b0;
`ifdef DEMUX4_TDM_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      out_valid  <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= err;
`ifdef DEMUX4_TDM_PARITY_EN
      par_err    <= 1'b0;
`endif
      if (acc) begin
        case (lane)
          2'd0:    out0 <= din;
          2'd1:    out1 <= din;
          2'd2:    out2 <= din;
          default: out3 <= din;
        endcase
        out_valid  <= 4'b0001 << lane;
        frame_done <= (lane == 2'd3);
        slot       <= lane + 2'd1;  // wraps 3 -> 0
        state      <= LOCKED;
        locked     <= 1'b1;
`ifdef DEMUX4_TDM_PARITY_EN
        // Even parity: din plus din_par must carry an even number of ones.
        par_err    <= ^{din, din_par};
`endif
      end
      if (lose) begin
        state  <= HUNT;
        locked <= 1'b0;
        slot   <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_demux4_tdm_rx.sv
// tb/tb_demux4_tdm_rx.sv - self-checking bench for demux4_tdm_rx

module tb_demux4_tdm_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] out0, out1, out2, out3;
  logic [3:0]   out_valid;
  logic         frame_done;
  logic         sync_err;
  logic         locked;
`ifdef DEMUX4_TDM_PARITY_EN
  logic         din_par;
  logic         par_err;
`endif

  demux4_tdm_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
`ifdef DEMUX4_TDM_PARITY_EN
    ,
    .din_par    (din_par),
    .par_err    (par_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame position and captured lanes, per the spec rules.
  bit           m_locked;
  int           m_pos;
  logic [W-1:0] m_lane [4];
  logic [3:0]   e_ov;
  logic         e_fd, e_se, e_pe;

  typedef struct {
    logic [W-1:0] d;
    logic         v;
    logic         s;
    logic [3:0]   ov;
    logic         fd;
    logic         se;
    logic         lk;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_pos    = 0;
    for (int i = 0; i < 4; i++) m_lane[i] = '0;
    e_ov = 0; e_fd = 0; e_se = 0; e_pe = 0;
  endtask

  task automatic model_accept(input int l, input logic [W-1:0] d, input logic p);
    m_lane[l] = d;
    e_ov      = 4'(1 << l);
    e_fd      = (l == 3);
    e_pe      = ($countones({d, p}) % 2) != 0;
    m_locked  = 1;
    m_pos     = (l + 1) % 4;
  endtask

  task automatic model_step(input logic [W-1:0] d, input logic v, input logic s, input logic p);
    e_ov = 0; e_fd = 0; e_se = 0; e_pe = 0;
    if (v) begin
      if (!m_locked) begin
        if (s) model_accept(0, d, p);
      end else if (s && m_pos != 0) begin
        e_se = 1;
        model_accept(0, d, p);
      end else if (!s && m_pos == 0) begin
        e_se     = 1;
        m_locked = 0;
        m_pos    = 0;
      end else begin
        model_accept(m_pos, d, p);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out0"}, 32'(out0), 32'(m_lane[0]));
    chk({tag, ".out1"}, 32'(out1), 32'(m_lane[1]));
    chk({tag, ".out2"}, 32'(out2), 32'(m_lane[2]));
    chk({tag, ".out3"}, 32'(out3), 32'(m_lane[3]));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
    chk({tag, ".sync_err"}, 32'(sync_err), 32'(e_se));
    chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
    chk({tag, ".onehot"}, 32'($countones(out_valid) <= 1), 32'd1);
`ifdef DEMUX4_TDM_PARITY_EN
    chk({tag, ".par_err"}, 32'(par_err), 32'(e_pe));
`endif
  endtask

  // Drive one cycle at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input string tag, input logic [W-1:0] d, input logic v,
                      input logic s, input logic p);
    @(negedge clk);
    din        = d;
    din_valid  = v;
    frame_sync = s;
`ifdef DEMUX4_TDM_PARITY_EN
    din_par    = p;
`endif
    model_step(d, v, s, p);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic add(input logic [W-1:0] d, input logic v, input logic s,
                     input logic [3:0] ov, input logic fd, input logic se, input logic lk);
    vec_t t;
    t.d = d; t.v = v; t.s = s; t.ov = ov; t.fd = fd; t.se = se; t.lk = lk;
    tbl.push_back(t);
  endtask

  function automatic logic even_par(input logic [W-1:0] d);
    return ^d;
  endfunction

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
`ifdef DEMUX4_TDM_PARITY_EN
    din_par = 1'b0;
`endif
    model_reset();

    // Basic frame with a leading dropped word.
    add(8'h11, 1, 0, 4'b0000, 0, 0, 0);
    add(8'hA0, 1, 1, 4'b0001, 0, 0, 1);
    add(8'hA1, 1, 0, 4'b0010, 0, 0, 1);
    add(8'hA2, 1, 0, 4'b0100, 0, 0, 1);
    add(8'hA3, 1, 0, 4'b1000, 1, 0, 1);
    // Two back-to-back frames.
    add(8'hB0, 1, 1, 4'b0001, 0, 0, 1);
    add(8'hB1, 1, 0, 4'b0010, 0, 0, 1);
    add(8'hB2, 1, 0, 4'b0100, 0, 0, 1);
    add(8'hB3, 1, 0, 4'b1000, 1, 0, 1);
    add(8'hC0, 1, 1, 4'b0001, 0, 0, 1);
    add(8'hC1, 1, 0, 4'b0010, 0, 0, 1);
    add(8'hC2, 1, 0, 4'b0100, 0, 0, 1);
    add(8'hC3, 1, 0, 4'b1000, 1, 0, 1);
    // Idle cycle with sync: ignored.
    add(8'h77, 0, 1, 4'b0000, 0, 0, 1);
    // Early sync on the third word.
    add(8'hD0, 1, 1, 4'b0001, 0, 0, 1);
    add(8'hD1, 1, 0, 4'b0010, 0, 0, 1);
    add(8'hD2, 1, 1, 4'b0001, 0, 1, 1);
    add(8'hD3, 1, 0, 4'b0010, 0, 0, 1);
    add(8'h55, 1, 0, 4'b0100, 0, 0, 1);
    add(8'h56, 1, 0, 4'b1000, 1, 0, 1);
    // Missing sync at slot 0: loss of lock, then hunting drops words.
    add(8'hE0, 1, 0, 4'b0000, 0, 1, 0);
    add(8'hE1, 1, 0, 4'b0000, 0, 0, 0);

    // Reset state, asynchronous, before any clock edge matters.
    #2;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step($sformatf("tbl%0d", i), tbl[i].d, tbl[i].v, tbl[i].s, even_par(tbl[i].d));
      chk($sformatf("tbl%0d.ov", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d.fd", i), 32'(frame_done), 32'(tbl[i].fd));
      chk($sformatf("tbl%0d.se", i), 32'(sync_err), 32'(tbl[i].se));
      chk($sformatf("tbl%0d.lk", i), 32'(locked), 32'(tbl[i].lk));
    end
    chk("tbl.final_out0", 32'(out0), 32'h55 - 32'h55 + 32'hD2);
    chk("tbl.final_out1", 32'(out1), 32'hD3);

    // Asynchronous reset mid-frame, between clock edges.
    step("rst.f0", 8'hF0, 1, 1, even_par(8'hF0));
    step("rst.f1", 8'hF1, 1, 0, even_par(8'hF1));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst0", 8'hF2, 1, 0, even_par(8'hF2));
    step("post_rst1", 8'hF3, 1, 0, even_par(8'hF3));
    chk("post_rst.locked", 32'(locked), 32'd0);
    chk("post_rst.out2", 32'(out2), 32'd0);

`ifdef DEMUX4_TDM_PARITY_EN
    step("par.sync", 8'h10, 1, 1, even_par(8'h10));
    step("par.bad", 8'h03, 1, 0, 1'b1);
    chk("par.bad_pulse", 32'(par_err), 32'd1);
    chk("par.bad_written", 32'(out1), 32'h03);
    step("par.good", 8'h03, 1, 0, 1'b0);
    chk("par.good_pulse", 32'(par_err), 32'd0);
`endif

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [W-1:0] d;
      logic v, s, p;
      d = W'($urandom);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) < 3);
      p = ($urandom_range(0, 7) == 0) ? ~even_par(d) : even_par(d);
      step("rand", d, v, s, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
